// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto one APB slave, running
// the SETUP/ACCESS transfer, waiting (bounded) for read data and pulsing done.
module apb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_done,
  output logic               req_err,
  output logic [DW-1:0]      req_rdata,
  output logic               busy,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RDWAIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   id_r;
  logic [7:0]      cnt_r;
  logic [IW-1:0]   grant_id_s;
  logic            grant_any_s;
  logic [NREQ-1:0] done_vec_s;
  int              idx_s;

  // Round-robin pick: first requester at or above ptr_r, wrapping around.
  always_comb begin
    grant_id_s  = '0;
    grant_any_s = 1'b0;
    idx_s       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr_r) + k) % NREQ;
      if (!grant_any_s && req[idx_s]) begin
        grant_any_s = 1'b1;
        grant_id_s  = IW'(idx_s);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  assign done_vec_s = {{(NREQ-1){1'b0}}, 1'b1} << id_r;

  // Transfer sequencer; bus, done and busy outputs are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      id_r      <= '0;
      cnt_r     <= 8'd0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          req_done <= '0;
          req_err  <= 1'b0;
          if (grant_any_s) begin
            id_r    <= grant_id_s;
            pwrite  <= req_we[grant_id_s];
            paddr   <= req_addr[int'(grant_id_s)*AW +: AW];
            pwdata  <= req_wdata[int'(grant_id_s)*DW +: DW];
            psel    <= 1'b1;
            penable <= 1'b0;
            busy    <= 1'b1;
            state_r <= SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (pwrite) begin
            req_done <= done_vec_s;
            req_err  <= 1'b0;
            state_r  <= DONE;
          end else begin
            cnt_r   <= 8'd0;
            state_r <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (valid) begin
            req_rdata <= prdata;
            req_err   <= 1'b0;
            req_done  <= done_vec_s;
            state_r   <= DONE;
          end else if ((cnt_r + 8'd1) == 8'(TIMEOUT)) begin
            // Slave never answered: report an all-ones word flagged as error.
            cnt_r     <= cnt_r + 8'd1;
            req_rdata <= {DW{1'b1}};
            req_err   <= 1'b1;
            req_done  <= done_vec_s;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          req_done <= '0;
          req_err  <= 1'b0;
          busy     <= 1'b0;
          ptr_r    <= (int'(id_r) == NREQ - 1) ? '0 : id_r + IW'(1);
          state_r  <= IDLE;
        end
        default: begin
          psel     <= 1'b0;
          penable  <= 1'b0;
          req_done <= '0;
          req_err  <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed and randomized bench for apb_req_arbiter with a small APB word
// memory slave and a cycle-level round-robin reference model.
module tb_apb_req_arbiter;

  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, req_we, req_done;
  logic [63:0]   req_addr, req_wdata;
  logic          req_err, busy, psel, penable, pwrite;
  logic [31:0]   req_rdata, paddr, pwdata, prdata;
  logic          valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  bit          mem_init = 1'b0;
  bit          rd_pend = 1'b0;
  bit          valid_en = 1'b1;

  apb_req_arbiter #(.NREQ(2), .AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_done(req_done), .req_err(req_err),
    .req_rdata(req_rdata), .busy(busy), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .valid(valid)
  );

  always #5 clk = ~clk;

  // Word-memory slave: writes in ACCESS, answers reads with a one-cycle valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid   = 1'b0;
      rd_pend = 1'b0;
      if (!mem_init) begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        prdata   = 32'h0;
        mem_init = 1'b1;
      end
    end else begin
      valid = rd_pend && valid_en;
      if (rd_pend) prdata = mem[paddr[3:0]];
      rd_pend = 1'b0;
      if (psel && penable) begin
        if (pwrite) mem[paddr[3:0]] = pwdata;
        else        rd_pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
    req_we[i]            = we;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req[i]               = 1'b1;
  endtask

  task automatic wait_done(input int limit, output logic [1:0] d, output int n);
    d = 2'b00;
    n = 0;
    while (n < limit && d == 2'b00) begin
      tick();
      n++;
      d = req_done;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  d;
    int          n;
    int          grant_cyc, done_cyc, next_arb, mptr, cur, w;
    bit          cur_we, found;
    logic [31:0] cur_addr, exp_rd;
    logic [1:0]  exp_done;

    rst_n = 1'b0; req = 2'b00; req_we = 2'b00; req_addr = 64'h0; req_wdata = 64'h0;
    repeat (3) tick();
    check("rst_psel", psel, 32'h0);
    check("rst_penable", penable, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_done", req_done, 32'h0);
    check("rst_err", req_err, 32'h0);
    check("rst_rdata", req_rdata, 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pwrite", pwrite, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single write
    set_req(0, 1'b1, 32'h5, 32'hDEADBEEF);
    tick();
    check("w_setup_psel", psel, 32'h1);
    check("w_setup_penable", penable, 32'h0);
    check("w_setup_paddr", paddr, 32'h5);
    check("w_setup_pwrite", pwrite, 32'h1);
    check("w_setup_busy", busy, 32'h1);
    tick();
    check("w_access_psel", psel, 32'h1);
    check("w_access_penable", penable, 32'h1);
    check("w_access_pwdata", pwdata, 32'hDEADBEEF);
    tick();
    check("w_done", req_done, 32'h1);
    check("w_err", req_err, 32'h0);
    req[0] = 1'b0;
    tick();
    check("w_done_clear", req_done, 32'h0);
    check("w_idle_busy", busy, 32'h0);
    check("w_mem5", mem[5], 32'hDEADBEEF);

    // Single read from requester 1
    set_req(1, 1'b0, 32'h5, 32'h0);
    wait_done(10, d, n);
    check("r_done", d, 32'h2);
    check("r_latency", n, 32'd4);
    check("r_rdata", req_rdata, 32'hDEADBEEF);
    check("r_err", req_err, 32'h0);
    req[1] = 1'b0;
    tick();

    // Contention from reset, then rotation against a repeated req[0]
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    set_req(0, 1'b0, 32'h1, 32'h0);
    set_req(1, 1'b0, 32'h2, 32'h0);
    wait_done(10, d, n);
    check("c_first", d, 32'h1);
    check("c_first_lat", n, 32'd4);
    check("c_first_rdata", req_rdata, mem[1]);
    req_addr[31:0] = 32'h3;
    wait_done(10, d, n);
    check("c_second", d, 32'h2);
    check("c_second_lat", n, 32'd5);
    check("c_second_rdata", req_rdata, mem[2]);
    req[1] = 1'b0;
    wait_done(10, d, n);
    check("c_third", d, 32'h1);
    check("c_third_rdata", req_rdata, mem[3]);
    req[0] = 1'b0;
    tick();

    // Read timeout with valid held low
    valid_en = 1'b0;
    set_req(0, 1'b0, 32'h9, 32'h0);
    wait_done(40, d, n);
    check("to_done", d, 32'h1);
    check("to_latency", n, 32'd18);
    check("to_err", req_err, 32'h1);
    check("to_rdata", req_rdata, 32'hFFFFFFFF);
    req[0] = 1'b0;
    tick();
    check("to_busy_after", busy, 32'h0);
    check("to_err_after", req_err, 32'h0);
    valid_en = 1'b1;

    // Reset asserted during ACCESS
    set_req(0, 1'b1, 32'hA, 32'h12345678);
    tick(); tick();
    check("rm_access_penable", penable, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rm_psel", psel, 32'h0);
    check("rm_penable", penable, 32'h0);
    check("rm_busy", busy, 32'h0);
    req[0] = 1'b0;
    tick();
    check("rm_no_done", req_done, 32'h0);
    rst_n = 1'b1;
    tick();
    set_req(0, 1'b1, 32'h7, 32'hCAFE0007);
    wait_done(10, d, n);
    check("rm_new_done", d, 32'h1);
    check("rm_new_lat", n, 32'd3);
    req[0] = 1'b0;
    tick();
    check("rm_mem7", mem[7], 32'hCAFE0007);

    // Back-to-back writes from requester 0
    set_req(0, 1'b1, 32'h0, 32'hB0B00000);
    for (int a = 0; a < 4; a++) begin
      wait_done(10, d, n);
      check("b2b_done", d, 32'h1);
      check("b2b_spacing", n, (a == 0) ? 32'd3 : 32'd4);
      if (a < 3) begin
        req_addr[31:0]  = 32'(a + 1);
        req_wdata[31:0] = 32'hB0B00000 + 32'(a + 1);
      end else begin
        req[0] = 1'b0;
      end
    end
    tick();
    for (int a = 0; a < 4; a++) check("b2b_mem", mem[a], 32'hB0B00000 + 32'(a));

    // Randomized traffic against the round-robin reference model
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    grant_cyc = -100; done_cyc = -100; next_arb = 0; mptr = 0; cur = 0;
    cur_we = 1'b0; cur_addr = 32'h0; exp_rd = 32'h0;
    for (int t = 0; t < 600; t++) begin
      exp_done = (t == done_cyc) ? (2'b01 << cur) : 2'b00;
      check("rnd_done", req_done, exp_done);
      check("rnd_busy", busy, (t > grant_cyc && t <= done_cyc) ? 32'h1 : 32'h0);
      if (t == grant_cyc + 1) check("rnd_paddr", paddr, cur_addr);
      if (t == done_cyc) begin
        check("rnd_err", req_err, 32'h0);
        if (!cur_we) check("rnd_rdata", req_rdata, exp_rd);
        req[cur] = 1'b0;
      end
      if (t < 560) begin
        for (int i = 0; i < NR; i++)
          if (!req[i] && !(t == done_cyc && i == cur) && $urandom_range(0, 2) == 0)
            set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
      end
      if (t >= next_arb && req != 2'b00) begin
        found = 1'b0; w = 0;
        for (int k = 0; k < NR; k++)
          if (!found && req[(mptr + k) % NR]) begin
            found = 1'b1;
            w = (mptr + k) % NR;
          end
        cur      = w;
        cur_we   = req_we[w];
        cur_addr = req_addr[w*32 +: 32];
        if (cur_we) ref_mem[cur_addr[3:0]] = req_wdata[w*32 +: 32];
        else        exp_rd = ref_mem[cur_addr[3:0]];
        grant_cyc = t;
        done_cyc  = t + (cur_we ? 3 : 4);
        next_arb  = done_cyc + 1;
        mptr      = (w + 1) % NR;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter and APB master sequencer.
- Shares the single APB word-memory slave between NREQ requesters, e.g. CPU instruction fetch and data port in the simulation top.
- Latches one request, drives the two-phase SETUP/ENABLE transfer, captures read data on the slave's one-cycle valid pulse, and returns a done pulse to the granted requester.
- A read-timeout counter guarantees forward progress if valid never arrives.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 15, max cycles waiting for slave valid after a read ENABLE phase (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until the matching req_done.
- req_we  in  NREQ  per-requester write (1) / read (0).
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_done  out  NREQ  one-cycle completion pulse, one-hot.
- req_err  out  1  valid with req_done; 1 = read timed out.
- req_rdata  out  DW  read data, valid with req_done of a read; held until the next done.
- busy  out  1  high in any state other than IDLE.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data from slave.
- valid  in  1  slave read-data-valid pulse.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 (psel, penable, pwrite, paddr, pwdata, req_done, req_err, req_rdata, busy); FSM=IDLE; rr pointer=0; timeout counter=0. Reset mid-transfer drops psel immediately and the transfer is abandoned with no done. Requesters re-issue after reset.
- FSM states: IDLE, SETUP, ACCESS, RDWAIT, DONE.
- IDLE:
  - If any req bit is set, pick the winner by round-robin starting at index ptr, ascending with wrap.
  - Latch winner id, we, addr and wdata into registers; go to SETUP.
  - Requests that drop before being granted are ignored.
- SETUP (1 cycle): psel=1, penable=0, pwrite/paddr/pwdata from the latched registers. Next state is ACCESS.
- ACCESS (1 cycle): psel=1, penable=1, same address/data.
  - Write: next state DONE.
  - Read: next state RDWAIT, counter cleared to 0.
- RDWAIT: psel=0, penable=0.
  - If valid=1: capture prdata into req_rdata, req_err=0, go to DONE.
  - Else increment the counter; when the counter reaches TIMEOUT, req_rdata={DW{1'b1}}, req_err=1, go to DONE.
- DONE (1 cycle):
  - req_done[id]=1, all other done bits 0.
  - ptr <= id+1, mod NREQ.
  - Next state IDLE.
- req_done and req_err are 0 in every state except DONE.
- Latency, grant in cycle 0 (IDLE):
  - Write: SETUP c1, ACCESS c2, DONE c3.
  - Read with slave valid at c3: RDWAIT c3, DONE c4 with data.
  - Next arbitration is in the IDLE cycle following DONE.
- Requester protocol:
  - Drop req in the cycle after req_done, or it is treated as a new request.
  - The round-robin pointer has already moved past it, so a competing requester wins first.
- Simultaneous requests: lowest index at or above ptr wins. At reset ptr=0, so requester 0 wins.
- Bus outputs paddr/pwdata/pwrite hold their last value outside SETUP/ACCESS; only psel/penable return to 0.
- No address range checking; paddr is passed through unmodified.
- A valid pulse outside RDWAIT is ignored.

Test Plan:
- Single write: req[0]=1, we=1, addr=0x05, wdata=0xDEADBEEF -> psel=1/penable=0 at c1; psel=1/penable=1 at c2; req_done=2'b01 at c3; slave mem[5]=0xDEADBEEF.
- Single read: req[1]=1, we=0, addr=0x05 after the write -> req_done=2'b10 at c4; req_rdata=0xDEADBEEF; req_err=0.
- Contention: req=2'b11 from reset, both reads of addr 0x01/0x02 -> requester 0 served first, then 1. A repeated req[0] issued together with a new req[1] grants 1 first (rotation).
- Timeout: read with valid tied 0, TIMEOUT=15 -> req_done after 15 RDWAIT cycles; req_err=1; req_rdata=0xFFFFFFFF; busy=0 the next cycle.
- Reset mid-transfer: assert rst_n=0 during ACCESS -> psel, penable and busy are 0 in the same cycle; no req_done. After release, a new write to 0x07 completes normally.
- Back-to-back writes from requester 0 to addresses 0..3 -> four done pulses 4 cycles apart; mem[0..3] correct.
